// File: rtl/matmul_seq_ctrl_if.sv
// matmul_seq_ctrl_if: start/status, A/B operand read and C result write bus.
// master = sequencer side, slave = buffer/environment side.
interface matmul_seq_ctrl_if #(
  parameter int AW_A = 3,
  parameter int AW_B = 4,
  parameter int AW_C = 3
);
  logic            start;
  logic            busy;
  logic            done;
  logic            a_rd_en;
  logic [AW_A-1:0] a_rd_addr;
  logic [31:0]     a_rd_data;
  logic            b_rd_en;
  logic [AW_B-1:0] b_rd_addr;
  logic [31:0]     b_rd_data;
  logic            res_wr_en;
  logic [AW_C-1:0] res_wr_addr;
  logic [31:0]     res_wr_data;
  logic            res_wr_ready;

  modport master (
    input  start,
    output busy,
    output done,
    output a_rd_en,
    output a_rd_addr,
    input  a_rd_data,
    output b_rd_en,
    output b_rd_addr,
    input  b_rd_data,
    output res_wr_en,
    output res_wr_addr,
    output res_wr_data,
    input  res_wr_ready
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  a_rd_en,
    input  a_rd_addr,
    output a_rd_data,
    input  b_rd_en,
    input  b_rd_addr,
    output b_rd_data,
    input  res_wr_en,
    input  res_wr_addr,
    input  res_wr_data,
    output res_wr_ready
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: C = A x B on one shared MAC lane, row-major over C.
// Ports: clk, rst_n (async low), bus (matmul_seq_ctrl_if.master).
// Option MATMUL_SEQ_CTRL_ACC_SAT_EN: signed operands, saturating acc.
module matmul_seq_ctrl #(
  parameter int left_size   = 2,
  parameter int middle_size = 3,
  parameter int right_size  = 4
) (
  input logic               clk,
  input logic               rst_n,
  matmul_seq_ctrl_if.master bus
);
  localparam int NA = left_size * middle_size;
  localparam int NB = middle_size * right_size;
  localparam int NC = left_size * right_size;
  localparam int AW_A = (NA > 1) ? $clog2(NA) : 1;
  localparam int AW_B = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW_C = (NC > 1) ? $clog2(NC) : 1;
  localparam int IW = (left_size > 1) ? $clog2(left_size) : 1;
  localparam int JW = (right_size > 1) ? $clog2(right_size) : 1;
  localparam int KW = (middle_size > 1) ? $clog2(middle_size) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAST, S_WRITE, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_i;
  logic [JW-1:0] r_j;
  logic [KW-1:0] r_k;
  logic [31:0]   r_acc;
  logic          r_pend;
  logic [31:0]   w_acc_nxt;
  logic          w_busy;
  logic          w_done;
  logic          w_rd;
  logic          w_wr;
  logic          w_k_last;
  logic          w_j_last;
  logic          w_i_last;
  logic          w_el_last;
  logic          w_accept;

  assign w_k_last  = (r_k == KW'(middle_size - 1));
  assign w_j_last  = (r_j == JW'(right_size - 1));
  assign w_i_last  = (r_i == IW'(left_size - 1));
  assign w_el_last = w_j_last & w_i_last;
  assign w_accept  = (r_state == S_WRITE) & bus.res_wr_ready;

`ifdef MATMUL_SEQ_CTRL_ACC_SAT_EN
  logic               r_sat;
  logic signed [63:0] w_prod;
  logic signed [65:0] w_sum;
  logic               w_ovf;

  assign w_prod = 64'($signed(bus.a_rd_data)) *
                  64'($signed(bus.b_rd_data));
  assign w_sum  = {{34{r_acc[31]}}, r_acc} +
                  {{2{w_prod[63]}}, w_prod};
  // Result fits in 32 bits only if bits 65..31 are all equal.
  assign w_ovf  = ~((&w_sum[65:31]) | ~(|w_sum[65:31]));

  always_comb begin
    w_acc_nxt = w_sum[31:0];
    if (r_sat)
      w_acc_nxt = r_acc;
    else if (w_ovf)
      w_acc_nxt = w_sum[65] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  // Once clamped, the element result stays pinned at the rail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sat <= 1'b0;
    else if ((r_state == S_IDLE) || w_accept)
      r_sat <= 1'b0;
    else if (r_pend && w_ovf)
      r_sat <= 1'b1;
  end
`else
  logic [31:0] w_prod;

  assign w_prod    = bus.a_rd_data * bus.b_rd_data;
  assign w_acc_nxt = r_acc + w_prod;
`endif

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_busy = 1'b1;
        w_rd   = 1'b1;
        if (w_k_last) w_next = S_LAST;
      end
      S_LAST: begin
        w_busy = 1'b1;
        w_next = S_WRITE;
      end
      S_WRITE: begin
        w_busy = 1'b1;
        w_wr   = 1'b1;
        if (bus.res_wr_ready)
          w_next = w_el_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // r_pend marks the cycle in which the previous read's data is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_acc  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_rd;
      if (r_pend)
        r_acc <= w_acc_nxt;
      if ((r_state == S_IDLE) && bus.start) begin
        r_i   <= '0;
        r_j   <= '0;
        r_k   <= '0;
        r_acc <= '0;
      end
      if ((r_state == S_FETCH) && !w_k_last)
        r_k <= r_k + 1'b1;
      if (w_accept) begin
        r_acc <= '0;
        r_k   <= '0;
        if (w_j_last) begin
          r_j <= '0;
          r_i <= w_i_last ? '0 : r_i + 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.a_rd_en     = w_rd;
  assign bus.b_rd_en     = w_rd;
  assign bus.res_wr_en   = w_wr;
  assign bus.a_rd_addr   = w_rd ?
    AW_A'(r_i) * AW_A'(middle_size) + AW_A'(r_k) : '0;
  assign bus.b_rd_addr   = w_rd ?
    AW_B'(r_k) * AW_B'(right_size) + AW_B'(r_j) : '0;
  assign bus.res_wr_addr = w_wr ?
    AW_C'(r_i) * AW_C'(right_size) + AW_C'(r_j) : '0;
  assign bus.res_wr_data = w_wr ? r_acc : '0;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: directed bench for matmul_seq_ctrl (2x3 * 3x4).
// Operand buffers modelled with one-cycle read latency.
module tb_matmul_seq_ctrl;
  logic clk;
  logic rst_n;

  matmul_seq_ctrl_if #(.AW_A(3), .AW_B(4), .AW_C(3)) bus();

  matmul_seq_ctrl #(
    .left_size(2), .middle_size(3), .right_size(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] amem [6];
  logic [31:0] bmem [12];
  logic [31:0] exp_c [8];

  always @(posedge clk) begin
    if (bus.a_rd_en) bus.a_rd_data <= amem[bus.a_rd_addr];
    if (bus.b_rd_en) bus.b_rd_data <= bmem[bus.b_rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;
  int base = 0;
  bit running = 1'b0;

  int wr_addr [16];
  int wr_data [16];
  int wr_cyc [16];
  int nwr;
  int rd_a [64];
  int rd_b [64];
  int nrd;
  int done_cnt, done_cyc;
  int busy_cnt, busy_first, busy_last;
  int stall_rd, ab_bad, rst_bad, hold0;

  task automatic clear_log();
    for (int n = 0; n < 16; n++) begin
      wr_addr[n] = 0; wr_data[n] = 0; wr_cyc[n] = 0;
    end
    nwr = 0; nrd = 0;
    done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; busy_first = -1; busy_last = -1;
    stall_rd = 0; ab_bad = 0; rst_bad = 0; hold0 = 0;
  endtask

  always @(negedge clk) begin
    #2;
    if (running) begin
      automatic int c = cyc - base;
      if (bus.res_wr_en && bus.res_wr_ready && nwr < 16) begin
        wr_addr[nwr] = int'(bus.res_wr_addr);
        wr_data[nwr] = int'(bus.res_wr_data);
        wr_cyc[nwr]  = c;
        nwr++;
      end
      if (bus.a_rd_en && nrd < 64) begin
        rd_a[nrd] = int'(bus.a_rd_addr);
        rd_b[nrd] = int'(bus.b_rd_addr);
        nrd++;
      end
      if (bus.done) begin done_cnt++; done_cyc = c; end
      if (bus.busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (bus.res_wr_en && (bus.a_rd_en || bus.b_rd_en)) stall_rd++;
      if (bus.a_rd_en !== bus.b_rd_en) ab_bad++;
      if (bus.res_wr_en && bus.res_wr_addr == 0 &&
          bus.res_wr_data == 32'd1) hold0++;
      if (!rst_n && (bus.busy || bus.done || bus.a_rd_en ||
          bus.b_rd_en || bus.res_wr_en || bus.a_rd_addr != 0 ||
          bus.b_rd_addr != 0 || bus.res_wr_addr != 0 ||
          bus.res_wr_data != 0)) rst_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start pulse sampled at edge 0; cycle n lies between edges n-1 and n.
  task automatic run(input int ncyc, input int stall_end,
                     input int rst_at, input bit pulses);
    clear_log();
    @(negedge clk);
    bus.start = 1'b1;
    bus.res_wr_ready = (stall_end == 0);
    base = cyc;
    running = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      bus.start = pulses && (n == 5 || n == 41);
      bus.res_wr_ready = (n >= stall_end);
      rst_n = !(rst_at > 0 && n >= rst_at && n < rst_at + 2);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic load_basic();
    amem[0] = 1; amem[1] = 2; amem[2] = 3;
    amem[3] = 4; amem[4] = 5; amem[5] = 6;
    for (int n = 0; n < 12; n++) bmem[n] = 0;
    bmem[0] = 1; bmem[3] = 1; bmem[5] = 1; bmem[7] = 1;
    bmem[10] = 1; bmem[11] = 1;
    exp_c[0] = 1; exp_c[1] = 2; exp_c[2] = 3; exp_c[3] = 6;
    exp_c[4] = 4; exp_c[5] = 5; exp_c[6] = 6; exp_c[7] = 15;
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_nwr"}, nwr, 8);
    for (int e = 0; e < 8; e++) begin
      chk($sformatf("%s_addr%0d", tag, e), wr_addr[e], e);
      chk($sformatf("%s_data%0d", tag, e), wr_data[e], exp_c[e]);
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_ab_eq"}, ab_bad, 0);
    chk({tag, "_stall_rd"}, stall_rd, 0);
  endtask

  task automatic load_ovf(input logic [31:0] a0, input logic [31:0] b0);
    for (int n = 0; n < 6; n++) amem[n] = 0;
    for (int n = 0; n < 12; n++) bmem[n] = 0;
    amem[0] = a0;
    bmem[0] = b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.res_wr_ready = 1'b1;
    bus.a_rd_data = '0;
    bus.b_rd_data = '0;
    clear_log();
    load_basic();
    #22;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_a_en", bus.a_rd_en, 0);
    chk("rst_b_en", bus.b_rd_en, 0);
    chk("rst_wr_en", bus.res_wr_en, 0);
    chk("rst_a_addr", bus.a_rd_addr, 0);
    chk("rst_b_addr", bus.b_rd_addr, 0);
    chk("rst_wr_addr", bus.res_wr_addr, 0);
    chk("rst_wr_data", bus.res_wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic product plus ignored start pulses at cycles 5 and 41.
    run(60, 0, 0, 1'b1);
    chk_seq("basic");
    chk("basic_last_wr_cyc", wr_cyc[7], 40);
    chk("basic_done_cyc", done_cyc, 41);
    chk("basic_busy_first", busy_first, 1);
    chk("basic_busy_last", busy_last, 40);
    chk("basic_busy_cnt", busy_cnt, 40);
    chk("basic_nrd", nrd, 24);
    chk("addr_a_k0", rd_a[18], 3);
    chk("addr_b_k0", rd_b[18], 2);
    chk("addr_a_k1", rd_a[19], 4);
    chk("addr_b_k1", rd_b[19], 6);
    chk("addr_a_k2", rd_a[20], 5);
    chk("addr_b_k2", rd_b[20], 10);

    // Backpressure on the first write for three cycles.
    run(60, 8, 0, 1'b0);
    chk_seq("bp");
    chk("bp_first_wr_cyc", wr_cyc[0], 8);
    chk("bp_hold_cycles", hold0, 4);
    chk("bp_done_cyc", done_cyc, 44);

    // Reset mid-run at cycle 17 for two cycles.
    run(60, 0, 17, 1'b0);
    chk("rst_mid_nwr", nwr, 3);
    chk("rst_mid_done", done_cnt, 0);
    chk("rst_mid_outputs", rst_bad, 0);
    chk("rst_mid_idle", bus.busy, 0);

    run(60, 0, 0, 1'b0);
    chk_seq("rerun");
    chk("rerun_done_cyc", done_cyc, 41);

    load_ovf(32'h0001_0000, 32'h0001_0000);
    run(50, 0, 0, 1'b0);
    chk("ovf1_nwr", nwr, 8);
`ifdef MATMUL_SEQ_CTRL_ACC_SAT_EN
    chk("ovf1_c00", wr_data[0], 32'h7FFF_FFFF);
`else
    chk("ovf1_c00", wr_data[0], 32'h0000_0000);
`endif
    chk("ovf1_c01", wr_data[1], 0);

    load_ovf(32'hFFFF_FFFF, 32'h8000_0000);
    run(50, 0, 0, 1'b0);
`ifdef MATMUL_SEQ_CTRL_ACC_SAT_EN
    chk("ovf2_c00", wr_data[0], 32'h7FFF_FFFF);
`else
    chk("ovf2_c00", wr_data[0], 32'h8000_0000);
`endif
    chk("ovf2_done", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
